// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// The starvation guard is enabled with the DMEM_ARB_STARVE_GUARD_EN macro.
package dmem_arb_pkg;

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      RD_WAIT = 1'b1
   } arb_state_t;

   localparam logic [3:0] XFER_DWORD   = 4'b1000;
   localparam int         MAX_READ_LAT = 8;

   // Width of the read-latency down-counter for a given READ_LAT.
   function automatic int lat_cnt_width(input int read_lat);
      return $clog2(read_lat + 1);
   endfunction

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating count of denied store-request cycles; force_st asserts at LIMIT.
// Only instantiated when DMEM_ARB_STARVE_GUARD_EN is defined.
module dmem_arb_starve_ctr #(
   parameter int LIMIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic inc,
   input  logic clr,
   output logic force_st
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] cnt_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_reg <= '0;
      end else if (clr) begin
         cnt_reg <= '0;
      end else if (inc && (cnt_reg != CW'(LIMIT))) begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

   assign force_st = (cnt_reg == CW'(LIMIT));

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the datamem port between loads (priority) and store commits.
// DMEM_ARB_STARVE_GUARD_EN adds a forced store grant after STARVE_LIMIT denials.
module dmem_port_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int READ_LAT = 1
`ifdef DMEM_ARB_STARVE_GUARD_EN
   ,
   parameter int STARVE_LIMIT = 4
`endif
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ld_req_valid,
   input  logic [63:0] ld_req_addr,
   output logic        ld_req_ready,
   output logic        ld_rsp_valid,
   output logic [63:0] ld_rsp_data,
   input  logic        st_req_valid,
   input  logic [63:0] st_req_addr,
   input  logic [63:0] st_req_data,
   output logic        st_req_ready,
   output logic [63:0] mem_address,
   output logic        mem_read_enable,
   output logic        mem_write_enable,
   output logic [63:0] mem_write_data,
   output logic [3:0]  mem_xfer_size,
   input  logic [63:0] mem_read_data
);

   localparam int CNT_W = lat_cnt_width(READ_LAT);

   arb_state_t        state_reg;
   logic [CNT_W-1:0]  cnt_reg;
   logic [63:0]       addr_reg;
   logic [63:0]       wdata_reg;
   logic              rsp_valid_reg;
   logic [63:0]       rsp_data_reg;

   logic idle;
   logic rd_wait;
   logic ld_grant;
   logic st_grant;
   logic last_read;
   logic force_st;

`ifdef DMEM_ARB_STARVE_GUARD_EN
   dmem_arb_starve_ctr #(
      .LIMIT(STARVE_LIMIT)
   ) u_starve_ctr (
      .clk      (clk),
      .reset    (reset),
      .inc      (st_req_valid && !st_grant),
      .clr      (st_grant),
      .force_st (force_st)
   );
`else
   assign force_st = 1'b0;
`endif

   // Grants are decided combinationally in IDLE and suppressed while reset is high.
   always_comb begin
      idle      = (state_reg == IDLE) && !reset;
      rd_wait   = (state_reg == RD_WAIT) && !reset;
      st_grant  = idle && st_req_valid && (!ld_req_valid || force_st);
      ld_grant  = idle && ld_req_valid && !st_grant;
      last_read = (ld_grant && (READ_LAT == 1)) ||
                  (rd_wait && (cnt_reg == CNT_W'(1)));
   end

   assign ld_req_ready     = ld_grant;
   assign st_req_ready     = st_grant;
   assign mem_read_enable  = ld_grant || rd_wait;
   assign mem_write_enable = st_grant;
   assign mem_address      = ld_grant ? ld_req_addr :
                             st_grant ? st_req_addr : addr_reg;
   assign mem_write_data   = st_grant ? st_req_data : wdata_reg;
   assign mem_xfer_size    = XFER_DWORD;
   assign ld_rsp_valid     = rsp_valid_reg;
   assign ld_rsp_data      = rsp_data_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         addr_reg      <= '0;
         wdata_reg     <= '0;
         rsp_valid_reg <= 1'b0;
         rsp_data_reg  <= '0;
      end else begin
         rsp_valid_reg <= last_read;
         if (last_read) begin
            rsp_data_reg <= mem_read_data;
         end
         if (ld_grant || st_grant) begin
            addr_reg <= mem_address;
         end
         if (st_grant) begin
            wdata_reg <= st_req_data;
         end
         case (state_reg)
            IDLE: begin
               if (ld_grant && (READ_LAT > 1)) begin
                  state_reg <= RD_WAIT;
                  cnt_reg   <= CNT_W'(READ_LAT - 1);
               end
            end
            RD_WAIT: begin
               cnt_reg <= cnt_reg - 1'b1;
               if (cnt_reg == CNT_W'(1)) begin
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench: instance a uses READ_LAT=1, instance b uses READ_LAT=3.
// Define DMEM_ARB_STARVE_GUARD_EN to exercise the starvation guard path.
module tb_dmem_port_arbiter;

   localparam int LAT_B = 3;
   localparam int LIMIT = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        a_reset, a_ld_v, a_ld_rdy, a_rsp_v, a_st_v, a_st_rdy, a_rd_en, a_wr_en;
   logic [63:0] a_ld_addr, a_rsp_data, a_st_addr, a_st_data, a_mem_addr, a_wdata, a_rdata;
   logic [3:0]  a_xfer;
   logic        b_reset, b_ld_v, b_ld_rdy, b_rsp_v, b_st_v, b_st_rdy, b_rd_en, b_wr_en;
   logic [63:0] b_ld_addr, b_rsp_data, b_st_addr, b_st_data, b_mem_addr, b_wdata, b_rdata;
   logic [3:0]  b_xfer;

   // Memory model: combinational read of a fixed address-to-data mapping.
   function automatic logic [63:0] mem_fn(input logic [63:0] a);
      if (a == 64'h40) return 64'hDEAD;
      return {a[31:0] ^ 32'h5A5A_0F0F, ~a[31:0]};
   endfunction

   assign a_rdata = mem_fn(a_mem_addr);
   assign b_rdata = mem_fn(b_mem_addr);

   dmem_port_arbiter #(.READ_LAT(1)) dut_a (
      .clk(clk), .reset(a_reset),
      .ld_req_valid(a_ld_v), .ld_req_addr(a_ld_addr), .ld_req_ready(a_ld_rdy),
      .ld_rsp_valid(a_rsp_v), .ld_rsp_data(a_rsp_data),
      .st_req_valid(a_st_v), .st_req_addr(a_st_addr), .st_req_data(a_st_data),
      .st_req_ready(a_st_rdy),
      .mem_address(a_mem_addr), .mem_read_enable(a_rd_en), .mem_write_enable(a_wr_en),
      .mem_write_data(a_wdata), .mem_xfer_size(a_xfer), .mem_read_data(a_rdata)
   );

   dmem_port_arbiter #(.READ_LAT(LAT_B)) dut_b (
      .clk(clk), .reset(b_reset),
      .ld_req_valid(b_ld_v), .ld_req_addr(b_ld_addr), .ld_req_ready(b_ld_rdy),
      .ld_rsp_valid(b_rsp_v), .ld_rsp_data(b_rsp_data),
      .st_req_valid(b_st_v), .st_req_addr(b_st_addr), .st_req_data(b_st_data),
      .st_req_ready(b_st_rdy),
      .mem_address(b_mem_addr), .mem_read_enable(b_rd_en), .mem_write_enable(b_wr_en),
      .mem_write_data(b_wdata), .mem_xfer_size(b_xfer), .mem_read_data(b_rdata)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        ld_v;
      logic [63:0] ld_addr;
      logic        st_v;
      logic [63:0] st_addr;
      logic [63:0] st_data;
      logic        e_ld_rdy;
      logic        e_st_rdy;
      logic        e_rd;
      logic        e_wr;
      logic [63:0] e_addr;
      logic [63:0] e_wdata;
      logic        e_rsp_v;
      logic [63:0] e_rsp_data;
   } vec_t;

   function automatic vec_t mk(input logic ld_v, input logic [63:0] ld_addr,
                               input logic st_v, input logic [63:0] st_addr,
                               input logic [63:0] st_data,
                               input logic e_ld_rdy, input logic e_st_rdy,
                               input logic e_rd, input logic e_wr,
                               input logic [63:0] e_addr, input logic [63:0] e_wdata,
                               input logic e_rsp_v, input logic [63:0] e_rsp_data);
      vec_t v;
      v.ld_v = ld_v; v.ld_addr = ld_addr; v.st_v = st_v; v.st_addr = st_addr;
      v.st_data = st_data; v.e_ld_rdy = e_ld_rdy; v.e_st_rdy = e_st_rdy;
      v.e_rd = e_rd; v.e_wr = e_wr; v.e_addr = e_addr; v.e_wdata = e_wdata;
      v.e_rsp_v = e_rsp_v; v.e_rsp_data = e_rsp_data;
      return v;
   endfunction

   vec_t vecs[11];

   typedef struct {
      int          due;
      logic [63:0] data;
   } rsp_t;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Random-phase model state
      rsp_t        rq[$];
      rsp_t        r;
      int          next_free;
      int          starve;
      int          n_ld_grant;
      int          n_rsp;
      int          n_ld_req;
      int          n_st_req;
      int          n_st_grant;
      logic        ld_pend, st_pend, exp_ld, exp_st, exp_rsp;
      logic [63:0] ld_addr, st_addr, st_data;

      a_reset = 1'b1; b_reset = 1'b1;
      a_ld_v = 1'b1; a_ld_addr = 64'h40; a_st_v = 1'b1; a_st_addr = 64'h80; a_st_data = 64'h1;
      b_ld_v = 1'b0; b_ld_addr = '0; b_st_v = 1'b0; b_st_addr = '0; b_st_data = '0;

      // Reset state and output gating while reset is high
      @(posedge clk); @(negedge clk);
      chk("rst_ld_ready", {63'd0, a_ld_rdy}, 64'd0);
      chk("rst_st_ready", {63'd0, a_st_rdy}, 64'd0);
      chk("rst_rd_en", {63'd0, a_rd_en}, 64'd0);
      chk("rst_wr_en", {63'd0, a_wr_en}, 64'd0);
      chk("rst_rsp_valid", {63'd0, a_rsp_v}, 64'd0);
      chk("rst_rsp_data", a_rsp_data, 64'd0);
      chk("rst_xfer_size", {60'd0, a_xfer}, 64'd8);
      $display("reset: readies %b%b enables %b%b", a_ld_rdy, a_st_rdy, a_rd_en, a_wr_en);
      @(posedge clk); #1;
      a_reset = 1'b0; b_reset = 1'b0; a_ld_v = 1'b0; a_st_v = 1'b0;

      // Table-driven vectors on the READ_LAT=1 instance
      vecs[0]  = mk(1'b0, 64'h0,   1'b0, 64'h0,   64'h0,      1'b0, 1'b0, 1'b0, 1'b0, 64'h0,   64'h0,      1'b0, 64'h0);
      vecs[1]  = mk(1'b1, 64'h40,  1'b0, 64'h0,   64'h0,      1'b1, 1'b0, 1'b1, 1'b0, 64'h40,  64'h0,      1'b0, 64'h0);
      vecs[2]  = mk(1'b0, 64'h0,   1'b0, 64'h0,   64'h0,      1'b0, 1'b0, 1'b0, 1'b0, 64'h40,  64'h0,      1'b1, 64'hDEAD);
      vecs[3]  = mk(1'b0, 64'h0,   1'b0, 64'h0,   64'h0,      1'b0, 1'b0, 1'b0, 1'b0, 64'h40,  64'h0,      1'b0, 64'h0);
      vecs[4]  = mk(1'b1, 64'h100, 1'b1, 64'h80,  64'h1234,   1'b1, 1'b0, 1'b1, 1'b0, 64'h100, 64'h0,      1'b0, 64'h0);
      vecs[5]  = mk(1'b0, 64'h0,   1'b1, 64'h80,  64'h1234,   1'b0, 1'b1, 1'b0, 1'b1, 64'h80,  64'h1234,   1'b1, mem_fn(64'h100));
      vecs[6]  = mk(1'b1, 64'h200, 1'b0, 64'h0,   64'h0,      1'b1, 1'b0, 1'b1, 1'b0, 64'h200, 64'h1234,   1'b0, 64'h0);
      vecs[7]  = mk(1'b1, 64'h208, 1'b0, 64'h0,   64'h0,      1'b1, 1'b0, 1'b1, 1'b0, 64'h208, 64'h1234,   1'b1, mem_fn(64'h200));
      vecs[8]  = mk(1'b0, 64'h0,   1'b0, 64'h0,   64'h0,      1'b0, 1'b0, 1'b0, 1'b0, 64'h208, 64'h1234,   1'b1, mem_fn(64'h208));
      vecs[9]  = mk(1'b0, 64'h0,   1'b1, 64'h300, 64'hABCD,   1'b0, 1'b1, 1'b0, 1'b1, 64'h300, 64'hABCD,   1'b0, 64'h0);
      vecs[10] = mk(1'b0, 64'h0,   1'b0, 64'h0,   64'h0,      1'b0, 1'b0, 1'b0, 1'b0, 64'h300, 64'hABCD,   1'b0, 64'h0);

      for (int i = 0; i < 11; i++) begin
         @(posedge clk); #1;
         a_ld_v = vecs[i].ld_v; a_ld_addr = vecs[i].ld_addr;
         a_st_v = vecs[i].st_v; a_st_addr = vecs[i].st_addr; a_st_data = vecs[i].st_data;
         @(negedge clk);
         chk($sformatf("vec%0d_ld_ready", i), {63'd0, a_ld_rdy}, {63'd0, vecs[i].e_ld_rdy});
         chk($sformatf("vec%0d_st_ready", i), {63'd0, a_st_rdy}, {63'd0, vecs[i].e_st_rdy});
         chk($sformatf("vec%0d_rd_en", i), {63'd0, a_rd_en}, {63'd0, vecs[i].e_rd});
         chk($sformatf("vec%0d_wr_en", i), {63'd0, a_wr_en}, {63'd0, vecs[i].e_wr});
         chk($sformatf("vec%0d_mem_addr", i), a_mem_addr, vecs[i].e_addr);
         chk($sformatf("vec%0d_wdata", i), a_wdata, vecs[i].e_wdata);
         chk($sformatf("vec%0d_rsp_valid", i), {63'd0, a_rsp_v}, {63'd0, vecs[i].e_rsp_v});
         if (vecs[i].e_rsp_v)
            chk($sformatf("vec%0d_rsp_data", i), a_rsp_data, vecs[i].e_rsp_data);
         $display("vec %0d: ld %b st %b -> rdy %b%b en %b%b addr %h rsp %b %h",
                  i, a_ld_v, a_st_v, a_ld_rdy, a_st_rdy, a_rd_en, a_wr_en,
                  a_mem_addr, a_rsp_v, a_rsp_data);
      end

      // Load priority under contention, optionally with the starvation guard
      @(posedge clk); #1;
      a_st_v = 1'b1; a_st_addr = 64'h500; a_st_data = 64'h77;
`ifdef DMEM_ARB_STARVE_GUARD_EN
      for (int c = 1; c <= 6; c++) begin
         if (c != 6) begin
            a_ld_v = 1'b1; a_ld_addr = 64'h600 + 64'(8 * c);
         end
         @(negedge clk);
         chk($sformatf("starve_c%0d_st_ready", c), {63'd0, a_st_rdy}, {63'd0, (c == LIMIT + 1)});
         chk($sformatf("starve_c%0d_ld_ready", c), {63'd0, a_ld_rdy}, {63'd0, (c != LIMIT + 1)});
         $display("starve cycle %0d: ld_ready %b st_ready %b", c, a_ld_rdy, a_st_rdy);
         @(posedge clk); #1;
         if (c == LIMIT + 1) a_st_v = 1'b0;
      end
      a_ld_v = 1'b0; a_st_v = 1'b0;
`else
      for (int c = 1; c <= 8; c++) begin
         a_ld_v = 1'b1; a_ld_addr = 64'h600 + 64'(8 * c);
         @(negedge clk);
         chk($sformatf("prio_c%0d_st_ready", c), {63'd0, a_st_rdy}, 64'd0);
         chk($sformatf("prio_c%0d_ld_ready", c), {63'd0, a_ld_rdy}, 64'd1);
         $display("priority cycle %0d: ld_ready %b st_ready %b", c, a_ld_rdy, a_st_rdy);
         @(posedge clk); #1;
      end
      a_ld_v = 1'b0;
      @(negedge clk);
      chk("prio_store_after", {63'd0, a_st_rdy}, 64'd1);
      chk("prio_store_addr", a_mem_addr, 64'h500);
      @(posedge clk); #1;
      a_st_v = 1'b0;
`endif

      // READ_LAT=3: store stalled behind a load in RD_WAIT
      @(posedge clk); #1;
      b_ld_v = 1'b1; b_ld_addr = 64'h40;
      @(negedge clk);
      chk("lat3_grant_ld_ready", {63'd0, b_ld_rdy}, 64'd1);
      chk("lat3_grant_rd_en", {63'd0, b_rd_en}, 64'd1);
      @(posedge clk); #1;
      b_ld_v = 1'b0; b_st_v = 1'b1; b_st_addr = 64'h80; b_st_data = 64'h55;
      for (int k = 1; k <= 2; k++) begin
         @(negedge clk);
         chk($sformatf("lat3_T%0d_ld_ready", k), {63'd0, b_ld_rdy}, 64'd0);
         chk($sformatf("lat3_T%0d_st_ready", k), {63'd0, b_st_rdy}, 64'd0);
         chk($sformatf("lat3_T%0d_rd_en", k), {63'd0, b_rd_en}, 64'd1);
         chk($sformatf("lat3_T%0d_wr_en", k), {63'd0, b_wr_en}, 64'd0);
         chk($sformatf("lat3_T%0d_addr", k), b_mem_addr, 64'h40);
         chk($sformatf("lat3_T%0d_rsp_valid", k), {63'd0, b_rsp_v}, 64'd0);
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("lat3_T3_rsp_valid", {63'd0, b_rsp_v}, 64'd1);
      chk("lat3_T3_rsp_data", b_rsp_data, 64'hDEAD);
      chk("lat3_T3_st_ready", {63'd0, b_st_rdy}, 64'd1);
      chk("lat3_T3_wr_en", {63'd0, b_wr_en}, 64'd1);
      chk("lat3_T3_rd_en", {63'd0, b_rd_en}, 64'd0);
      chk("lat3_T3_addr", b_mem_addr, 64'h80);
      $display("lat3 stall: rsp %b %h, store granted %b", b_rsp_v, b_rsp_data, b_st_rdy);
      @(posedge clk); #1;
      b_st_v = 1'b0;
      @(negedge clk);
      chk("lat3_T4_rsp_valid", {63'd0, b_rsp_v}, 64'd0);

      // READ_LAT=3: reset during RD_WAIT abandons the read
      @(posedge clk); #1;
      b_ld_v = 1'b1; b_ld_addr = 64'h48;
      @(negedge clk);
      chk("rstmid_grant", {63'd0, b_ld_rdy}, 64'd1);
      @(posedge clk); #1;
      b_ld_v = 1'b0; b_reset = 1'b1;
      @(negedge clk);
      chk("rstmid_rd_en_in_reset", {63'd0, b_rd_en}, 64'd0);
      @(posedge clk); #1;
      b_reset = 1'b0;
      @(negedge clk);
      chk("rstmid_T2_rd_en", {63'd0, b_rd_en}, 64'd0);
      chk("rstmid_T2_wr_en", {63'd0, b_wr_en}, 64'd0);
      chk("rstmid_T2_addr", b_mem_addr, 64'h0);
      chk("rstmid_T2_wdata", b_wdata, 64'h0);
      chk("rstmid_T2_rsp_data", b_rsp_data, 64'h0);
      for (int k = 2; k <= 4; k++) begin
         chk($sformatf("rstmid_T%0d_rsp_valid", k), {63'd0, b_rsp_v}, 64'd0);
         @(posedge clk); #1;
         @(negedge clk);
      end
      $display("reset mid-read: no response produced");
      @(posedge clk); #1;
      b_ld_v = 1'b1; b_ld_addr = 64'h50;
      @(negedge clk);
      chk("rstmid_new_grant", {63'd0, b_ld_rdy}, 64'd1);
      @(posedge clk); #1;
      b_ld_v = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rstmid_new_rsp_valid", {63'd0, b_rsp_v}, 64'd1);
      chk("rstmid_new_rsp_data", b_rsp_data, mem_fn(64'h50));
      repeat (3) @(posedge clk);

      // Random traffic on READ_LAT=3 against a request/grant-level model
      next_free = 0; starve = 0; n_ld_grant = 0; n_rsp = 0;
      n_ld_req = 0; n_st_req = 0; n_st_grant = 0;
      ld_pend = 1'b0; st_pend = 1'b0;
      ld_addr = '0; st_addr = '0; st_data = '0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         @(posedge clk); #1;
         if (!ld_pend && $urandom_range(0, 1) == 1) begin
            ld_pend = 1'b1; ld_addr = {$urandom, $urandom} & ~64'h7; n_ld_req++;
         end
         if (!st_pend && $urandom_range(0, 2) == 0) begin
            st_pend = 1'b1; st_addr = {$urandom, $urandom} & ~64'h7;
            st_data = {$urandom, $urandom}; n_st_req++;
         end
         b_ld_v = ld_pend; b_ld_addr = ld_addr;
         b_st_v = st_pend; b_st_addr = st_addr; b_st_data = st_data;
         exp_st = (cyc >= next_free) && st_pend;
`ifdef DMEM_ARB_STARVE_GUARD_EN
         exp_st = exp_st && (!ld_pend || starve == LIMIT);
`else
         exp_st = exp_st && !ld_pend;
`endif
         exp_ld  = (cyc >= next_free) && ld_pend && !exp_st;
         exp_rsp = (rq.size() > 0) && (rq[0].due == cyc);
         @(negedge clk);
         chk("rnd_ld_ready", {63'd0, b_ld_rdy}, {63'd0, exp_ld});
         chk("rnd_st_ready", {63'd0, b_st_rdy}, {63'd0, exp_st});
         chk("rnd_enable_excl", {63'd0, b_rd_en && b_wr_en}, 64'd0);
         chk("rnd_rsp_valid", {63'd0, b_rsp_v}, {63'd0, exp_rsp});
         if (exp_rsp) begin
            r = rq.pop_front();
            chk("rnd_rsp_data", b_rsp_data, r.data);
            n_rsp++;
         end
         if (exp_ld) begin
            chk("rnd_ld_addr", b_mem_addr, ld_addr);
            r.due = cyc + LAT_B; r.data = mem_fn(ld_addr);
            rq.push_back(r);
            next_free = cyc + LAT_B;
            ld_pend = 1'b0; n_ld_grant++;
         end
         if (exp_st) begin
            chk("rnd_st_addr", b_mem_addr, st_addr);
            chk("rnd_st_data", b_wdata, st_data);
            st_pend = 1'b0; starve = 0; n_st_grant++;
         end else if (st_pend) begin
            starve = (starve < LIMIT) ? starve + 1 : LIMIT;
         end
         chk("rnd_rd_en", {63'd0, b_rd_en}, {63'd0, (cyc < next_free)});
      end
      @(posedge clk); #1;
      b_ld_v = 1'b0; b_st_v = 1'b0;
      for (int k = 0; k < LAT_B + 1; k++) begin
         @(negedge clk);
         if (b_rsp_v) n_rsp++;
         @(posedge clk); #1;
      end
      chk("rnd_rsp_count", 64'(n_rsp), 64'(n_ld_grant));
      chk("rnd_ld_grants", 64'(n_ld_grant + (ld_pend ? 1 : 0)), 64'(n_ld_req));
      chk("rnd_st_grants", 64'(n_st_grant + (st_pend ? 1 : 0)), 64'(n_st_req));
      $display("random: %0d load grants, %0d responses, %0d store grants",
               n_ld_grant, n_rsp, n_st_grant);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
